// File: rtl/instruction_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package instruction_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
    } inst_info_t;

    typedef struct packed {
        inst_info_t  info;
        logic [31:0] inst;
    } iq_entry_t;

    localparam int unsigned IQ_DEPTH = 16;

endpackage

// File: rtl/instruction_queue.sv
// Circular FIFO between fetch and decode; first-word-fall-through head, flush empties it.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = IQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq,
    input  inst_info_t       enq_inst_info,
    input  logic [31:0]      enq_inst,
    input  logic             deq,
    output logic             deq_valid,
    output inst_info_t       deq_inst_info,
    output logic [31:0]      deq_inst,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "instruction_queue: DEPTH must be a power of two and >= 2");
    end

    localparam logic [PTR_W:0] PtrOne = 1;

    // MSB of each pointer is the wrap bit; the low PTR_W bits index storage.
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;
    iq_entry_t      mem [DEPTH];
    iq_entry_t      head_entry;
    logic           enq_fire;
    logic           deq_fire;

    assign empty     = (head_q == tail_q);
    assign full      = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                       (head_q[PTR_W] != tail_q[PTR_W]);
    assign count     = tail_q - head_q;
    assign deq_valid = !empty;

    assign enq_fire = enq && !full && !flush;
    assign deq_fire = deq && !empty && !flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PtrOne;
            if (deq_fire) head_d = head_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is deliberately left unreset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail_q[PTR_W-1:0]] <= '{info: enq_inst_info, inst: enq_inst};
        end
    end

    assign head_entry    = mem[head_q[PTR_W-1:0]];
    assign deq_inst_info = head_entry.info;
    assign deq_inst      = head_entry.inst;

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboarded random and directed bench for instruction_queue.
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        enq = 1'b0;
    logic        deq = 1'b0;
    inst_info_t  enq_inst_info = '0;
    logic [31:0] enq_inst = '0;
    logic        deq_valid;
    inst_info_t  deq_inst_info;
    logic [31:0] deq_inst;
    logic        full;
    logic        empty;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    int proto_err = 0;
    logic [63:0] rnd_ord = 64'd1000;
    logic [63:0] last_ord;

    // Reference: plain queue of entries, updated by the enqueue/dequeue rules.
    iq_entry_t model[$];

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .enq           (enq),
        .enq_inst_info (enq_inst_info),
        .enq_inst      (enq_inst),
        .deq           (deq),
        .deq_valid     (deq_valid),
        .deq_inst_info (deq_inst_info),
        .deq_inst      (deq_inst),
        .full          (full),
        .empty         (empty),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : ref_model
        int sz;
        if (!rst_n) begin
            model.delete();
        end else begin
            sz = model.size();
            if (!flush) begin
                if (enq && sz == DEPTH) proto_err++;
                if (deq && sz > 0) void'(model.pop_front());
                if (enq && sz < DEPTH) model.push_back('{info: enq_inst_info, inst: enq_inst});
            end else begin
                model.delete();
            end
        end
    end

    // Monitor: compares status and, when the head is valid, the head entry.
    always @(negedge clk) begin : monitor
        int sz;
        sz = model.size();
        check("count", 64'(count), 64'(sz));
        check("full", 64'(full), 64'(sz == DEPTH));
        check("empty", 64'(empty), 64'(sz == 0));
        check("deq_valid", 64'(deq_valid), 64'(sz > 0));
        if (sz > 0 && deq_valid) begin
            check("head_pc", 64'(deq_inst_info.pc), 64'(model[0].info.pc));
            check("head_pc_next", 64'(deq_inst_info.pc_next), 64'(model[0].info.pc_next));
            check("head_order", deq_inst_info.order, model[0].info.order);
            check("head_inst", 64'(deq_inst), 64'(model[0].inst));
        end
    end

    task automatic step(input logic e, input logic d, input logic f,
                        input logic [31:0] pc, input logic [63:0] ord);
        enq   = e;
        deq   = d;
        flush = f;
        enq_inst_info = '{pc: pc, pc_next: pc + 32'd4, order: ord};
        enq_inst = $urandom;
        @(negedge clk);
        #1;
        enq   = 1'b0;
        deq   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        // Reset then idle
        repeat (3) @(negedge clk);
        #1;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Fill to DEPTH, then one dropped enqueue while full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 32'h6000_0000 + 32'(4 * i), 64'(i));
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd16);
        check("fill_proto", 64'(proto_err), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'h6000_0040, 64'd16);
        check("overfill_count", 64'(count), 64'd16);
        check("overfill_proto", 64'(proto_err), 64'd1);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            check("drain_order", deq_inst_info.order, 64'(i));
            step(1'b0, 1'b1, 1'b0, 32'h0, 64'd0);
        end
        check("drain_empty", 64'(empty), 64'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 64'd0);
        check("underflow_count", 64'(count), 64'd0);

        // Steady stream at count 3 across pointer wraps
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h6000_1000 + 32'(4 * i), 64'(100 + i));
        last_ord = 64'd0;
        for (int i = 0; i < 40; i++) begin
            check("stream_increasing", 64'(deq_inst_info.order > last_ord), 64'd1);
            last_ord = deq_inst_info.order;
            step(1'b1, 1'b1, 1'b0, 32'h6000_2000 + 32'(4 * i), 64'(103 + i));
            check("stream_count", 64'(count), 64'd3);
        end

        // Flush beats same-cycle enq and deq
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h6000_3000 + 32'(4 * i), 64'(200 + i));
        check("preflush_count", 64'(count), 64'd9);
        step(1'b1, 1'b1, 1'b1, 32'h6000_4000, 64'd300);
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        step(1'b1, 1'b0, 1'b0, 32'h6000_0120, 64'd42);
        check("postflush_pc", 64'(deq_inst_info.pc), 64'h6000_0120);
        check("postflush_order", deq_inst_info.order, 64'd42);
        check("postflush_valid", 64'(deq_valid), 64'd1);

        // Async reset mid-stream
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h6000_5000 + 32'(4 * i), 64'(50 + i));
        check("prereset_count", 64'(count), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_empty", 64'(empty), 64'd1);
        check("async_count", 64'(count), 64'd0);
        check("async_valid", 64'(deq_valid), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h6000_0000, 64'd7);
        check("postreset_order", deq_inst_info.order, 64'd7);
        check("postreset_count", 64'(count), 64'd1);

        // Random traffic; fetch honours full
        for (int i = 0; i < 400; i++) begin
            logic e, d, f;
            e = (i < 200 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0))
                && (model.size() < DEPTH);
            d = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            step(e, d, f, $urandom, rnd_ord);
            rnd_ord = rnd_ord + 64'd1;
        end
        check("random_proto", 64'(proto_err), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
